// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-setting controller.
// Holds the FSM state enum, the edit_field codes and the capture clamp helper.
package time_set_pkg;

    localparam int TIME_W = 8;

    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        COMMIT
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Out-of-range running values are pinned to the top legal value on capture.
    function automatic logic [TIME_W-1:0] clamp_field(input logic [TIME_W-1:0] v,
                                                      input int modulus);
        if (int'(v) >= modulus) begin
            return TIME_W'(modulus - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/time_set_ctrl_wrap_step.sv
// Single-field modular step: +1 / -1 with wrap at the field modulus.
// inc and dec together cancel and leave the value unchanged.
module wrap_step
    import time_set_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic [TIME_W-1:0] value_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [TIME_W-1:0] next_o
);

    localparam logic [TIME_W-1:0] TOP = TIME_W'(MODULUS - 1);

    always_comb begin
        next_o = value_i;
        if (inc_i && !dec_i) begin
            next_o = (value_i == TOP) ? '0 : value_i + 1'b1;
        end else if (dec_i && !inc_i) begin
            next_o = (value_i == '0) ? TOP : value_i - 1'b1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller feeding en/modify/cur_*_modified to the clock.
// Optional idle auto-abort is enabled with the TIME_SET_TIMEOUT_EN macro.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int HOUR           = 24,
    parameter int MINUTE         = 60,
    parameter int SECOND         = 60,
    parameter int COMMIT_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_minute,
    input  logic [TIME_W-1:0] cur_second,
    output logic              en,
    output logic              modify,
    output logic [TIME_W-1:0] cur_hour_modified,
    output logic [TIME_W-1:0] cur_minute_modified,
    output logic [TIME_W-1:0] cur_second_modified,
    output logic [1:0]        edit_field
);

    localparam int CW = (COMMIT_CYCLES > 1) ? $clog2(COMMIT_CYCLES) : 1;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   en_q, en_d;
    logic                   modify_q, modify_d;
    logic [1:0]             field_q, field_d;
    logic [2:0][TIME_W-1:0] edit_q, edit_d, step, keep_vals;
    logic                   timeout;

    for (genvar gi = 0; gi < 3; gi++) begin : g_step
        wrap_step #(
            .MODULUS(gi == 0 ? HOUR : (gi == 1 ? MINUTE : SECOND))
        ) u_step (
            .value_i(edit_q[gi]),
            .inc_i  (btn_inc),
            .dec_i  (btn_dec),
            .next_o (step[gi])
        );
    end

`ifdef TIME_SET_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0]          idle_q;
    logic [2:0][TIME_W-1:0] keep_q;
    logic                   editing, any_btn;

    assign editing   = (field_q != FIELD_NONE);
    assign any_btn   = btn_mode | btn_inc | btn_dec;
    assign timeout   = editing && !any_btn && (idle_q == IW'(TIMEOUT_CYCLES - 1));
    assign keep_vals = keep_q;

    // keep_q remembers the last committed time so an abort can restore it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q <= '0;
            keep_q <= '0;
        end else begin
            idle_q <= (!editing || any_btn) ? '0 : idle_q + 1'b1;
            if (state_q == SET_SEC && btn_mode) begin
                keep_q <= edit_q;
            end
        end
    end
`else
    // Without the feature the abort path is constant-false.
    assign timeout   = (TIMEOUT_CYCLES < 0);
    assign keep_vals = edit_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            en_q     <= 1'b1;
            modify_q <= 1'b0;
            field_q  <= FIELD_NONE;
            edit_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            modify_q <= modify_d;
            field_q  <= field_d;
            edit_q   <= edit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN:      if (btn_mode) state_d = SET_HOUR;
            SET_HOUR: if (btn_mode) state_d = SET_MIN;
            SET_MIN:  if (btn_mode) state_d = SET_SEC;
            SET_SEC: begin
                if (btn_mode) begin
                    state_d = COMMIT;
                    cnt_d   = '0;
                end
            end
            COMMIT: begin
                if (cnt_q == CW'(COMMIT_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (timeout) begin
            state_d = RUN;
        end
    end

    // Outputs are decoded from the next state so they land in registers.
    always_comb begin
        en_d     = (state_d == RUN);
        modify_d = (state_d == COMMIT);
        case (state_d)
            SET_HOUR: field_d = FIELD_HOUR;
            SET_MIN:  field_d = FIELD_MIN;
            SET_SEC:  field_d = FIELD_SEC;
            default:  field_d = FIELD_NONE;
        endcase
    end

    always_comb begin
        edit_d = edit_q;
        if (state_q == RUN && btn_mode) begin
            edit_d[0] = clamp_field(cur_hour, HOUR);
            edit_d[1] = clamp_field(cur_minute, MINUTE);
            edit_d[2] = clamp_field(cur_second, SECOND);
        end else if (timeout) begin
            edit_d = keep_vals;
        end else if (!btn_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (field_q == 2'(i + 1)) begin
                    edit_d[i] = step[i];
                end
            end
        end
    end

    assign en                  = en_q;
    assign modify              = modify_q;
    assign edit_field          = field_q;
    assign cur_hour_modified   = edit_q[0];
    assign cur_minute_modified = edit_q[1];
    assign cur_second_modified = edit_q[2];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random button traffic
// compared every cycle against a behavioural model of the editing rules.
module tb_time_set_ctrl;

    localparam int TO = 10;

    logic       clk, rst;
    logic       btn_mode, btn_inc, btn_dec;
    logic [7:0] cur_hour, cur_minute, cur_second;
    logic       en, modify;
    logic [7:0] hour_mod, min_mod, sec_mod;
    logic [1:0] edit_field;

    int total = 0;
    int bad   = 0;

    time_set_ctrl #(
        .HOUR(24), .MINUTE(60), .SECOND(60), .COMMIT_CYCLES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .btn_mode           (btn_mode),
        .btn_inc            (btn_inc),
        .btn_dec            (btn_dec),
        .cur_hour           (cur_hour),
        .cur_minute         (cur_minute),
        .cur_second         (cur_second),
        .en                 (en),
        .modify             (modify),
        .cur_hour_modified  (hour_mod),
        .cur_minute_modified(min_mod),
        .cur_second_modified(sec_mod),
        .edit_field         (edit_field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 = running, 1..3 = editing hour/min/sec, 4 = committing.
    int m_mode;
    int m_left;
    int m_idle;
    int ed[3];
    int keep[3];
    int mods[3] = '{24, 60, 60};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_idle = 0;
        for (int i = 0; i < 3; i++) begin ed[i] = 0; keep[i] = 0; end
    endtask

    task automatic model_step(input bit bm, input bit bi, input bit bd);
        int cur[3];
        int f;
        cur[0] = cur_hour; cur[1] = cur_minute; cur[2] = cur_second;
        if (m_mode == 0) begin
            if (bm) begin
                for (int i = 0; i < 3; i++) ed[i] = (cur[i] >= mods[i]) ? mods[i] - 1 : cur[i];
                m_mode = 1;
                m_idle = 0;
            end
        end else if (m_mode <= 3) begin
            if (bm) begin
                m_idle = 0;
                if (m_mode == 3) begin
                    m_mode = 4;
                    m_left = 2;
                    for (int i = 0; i < 3; i++) keep[i] = ed[i];
                end else begin
                    m_mode++;
                end
            end else begin
                f = m_mode - 1;
                if (bi && !bd) ed[f] = (ed[f] + 1) % mods[f];
                else if (bd && !bi) ed[f] = (ed[f] + mods[f] - 1) % mods[f];
`ifdef TIME_SET_TIMEOUT_EN
                if (bi || bd) m_idle = 0;
                else m_idle++;
                if (m_idle == TO) begin
                    m_mode = 0;
                    m_idle = 0;
                    for (int i = 0; i < 3; i++) ed[i] = keep[i];
                end
`endif
            end
        end else begin
            m_left--;
            if (m_left == 0) m_mode = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".en"},     en,         (m_mode == 0) ? 1 : 0);
        check({tag, ".modify"}, modify,     (m_mode == 4) ? 1 : 0);
        check({tag, ".field"},  edit_field, (m_mode >= 1 && m_mode <= 3) ? m_mode : 0);
        check({tag, ".hour"},   hour_mod,   ed[0]);
        check({tag, ".min"},    min_mod,    ed[1]);
        check({tag, ".sec"},    sec_mod,    ed[2]);
    endtask

    // Called just after a negedge; inputs are applied for the coming posedge.
    task automatic cycle(input string tag, input bit bm, input bit bi, input bit bd);
        btn_mode = bm; btn_inc = bi; btn_dec = bd;
        @(posedge clk);
        model_step(bm, bi, bd);
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed inside the low phase, between edges.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        #2;
        rst = 1'b0;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 8'(h); cur_minute = 8'(m); cur_second = 8'(s);
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        set_cur(0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all("reset");
        rst = 1'b0;

        // Inc in RUN is ignored.
        for (int i = 0; i < 3; i++) cycle("run_inc", 1'b0, 1'b1, 1'b0);
        check("run_inc_en", en, 1);

        // Capture and hour wrap.
        set_cur(5, 3, 21);
        cycle("enter", 1'b1, 1'b0, 1'b0);
        check("enter_field", edit_field, 1);
        check("enter_en", en, 0);
        check("enter_hour", hour_mod, 5);
        for (int i = 0; i < 20; i++) cycle("hinc", 1'b0, 1'b1, 1'b0);
        check("hour_wrap", hour_mod, 1);
        cycle("to_min", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle("mdec", 1'b0, 1'b0, 1'b1);
        check("min_wrap", min_mod, 59);
        cycle("to_sec", 1'b1, 1'b0, 1'b0);
        cycle("to_commit", 1'b1, 1'b0, 1'b0);
        cycle("commit_a", 1'b0, 1'b0, 1'b0);
        cycle("commit_b", 1'b0, 1'b0, 1'b0);

        // Full pass: mode, inc, mode, mode, inc, mode.
        set_cur(5, 3, 21);
        cycle("p_enter", 1'b1, 1'b0, 1'b0);
        cycle("p_inc_h", 1'b0, 1'b1, 1'b0);
        cycle("p_min",   1'b1, 1'b0, 1'b0);
        cycle("p_sec",   1'b1, 1'b0, 1'b0);
        cycle("p_inc_s", 1'b0, 1'b1, 1'b0);
        cycle("p_commit", 1'b1, 1'b1, 1'b1);
        check("commit1_modify", modify, 1);
        check("commit1_hour", hour_mod, 6);
        check("commit1_min", min_mod, 3);
        check("commit1_sec", sec_mod, 22);
        cycle("p_c2", 1'b0, 1'b1, 1'b0);
        check("commit2_modify", modify, 1);
        cycle("p_run", 1'b0, 1'b0, 1'b0);
        check("after_modify", modify, 0);
        check("after_en", en, 1);
        check("after_sec", sec_mod, 22);

        // Simultaneous buttons.
        set_cur(12, 34, 56);
        cycle("s_enter", 1'b1, 1'b0, 1'b0);
        cycle("s_mode_inc", 1'b1, 1'b1, 1'b0);
        check("s_field", edit_field, 2);
        check("s_hour", hour_mod, 12);
        cycle("s_inc_dec", 1'b0, 1'b1, 1'b1);
        check("s_min", min_mod, 34);

        // Reset during the first commit cycle; captured 99 clamps to 59.
        cycle("r_sec", 1'b1, 1'b0, 1'b0);
        set_cur(0, 0, 99);
        cycle("r_commit", 1'b1, 1'b0, 1'b0);
        check("r_commit_mod", modify, 1);
        do_reset("mid_commit");
        check("r_modify_low", modify, 0);
        cycle("r_after", 1'b0, 1'b0, 1'b0);
        cycle("clamp_enter", 1'b1, 1'b0, 1'b0);
        check("clamp_sec", sec_mod, 59);

`ifdef TIME_SET_TIMEOUT_EN
        cycle("t_min", 1'b1, 1'b0, 1'b0);
        cycle("t_sec", 1'b1, 1'b0, 1'b0);
        cycle("t_commit", 1'b1, 1'b0, 1'b0);
        cycle("t_c2", 1'b0, 1'b0, 1'b0);
        cycle("t_run", 1'b0, 1'b0, 1'b0);
        set_cur(7, 8, 9);
        cycle("t_enter", 1'b1, 1'b0, 1'b0);
        cycle("t_inc", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TO; i++) begin
            cycle("t_idle", 1'b0, 1'b0, 1'b0);
            check("t_no_modify", modify, 0);
        end
        check("t_aborted", en, 1);
        check("t_hour_kept", hour_mod, keep[0]);
        cycle("t2_enter", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < TO - 2; i++) cycle("t2_idle", 1'b0, 1'b0, 1'b0);
            cycle("t2_btn", 1'b0, 1'b1, 1'b0);
        end
        check("t2_still_edit", en, 0);
`endif

        // Random traffic, including clamping inputs and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            set_cur($urandom_range(0, 255), $urandom_range(0, 70), $urandom_range(0, 70));
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                cycle("rnd", ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
